x_stream_source: RTL and testbench

AXI-Stream transmitter that drives the `x_tdata`/`x_tvalid`/`x_tready` input of the perceptron layer. It holds one input vector (one MNIST image) in a local single-clock RAM loaded through a simple write port. On a start edge it streams the vector `NUM_PASSES` times, one word per cycle under backpressure, with `x_tlast` marking each pass. It sits between the host/DMA image loader and one or more time-multiplexed perceptrons.

---
 rtl/x_src_pkg.sv | 21 ++
 rtl/x_src_skid.sv | 63 ++++++
 rtl/x_stream_source.sv | 165 ++++++++++++++++
 tb/tb_x_stream_source.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/x_src_pkg.sv
// Shared types and constants for the x_stream_source image streamer.
// Optional build macro used by the top level: X_SRC_PIXEL_NORM_EN.
package x_src_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        STREAM,
        DONE
    } x_src_state_t;

    localparam int FRAC_BITS  = 27;
    localparam int PIXEL_W    = 8;
    localparam int NORM_SHIFT = FRAC_BITS - PIXEL_W - 0;

    // An unsigned 8-bit pixel p becomes p/256 in signed Q4.27.
    function automatic logic [31:0] pixel_to_q427(input logic [PIXEL_W-1:0] p);
        return {{(32 - PIXEL_W){1'b0}}, p} << NORM_SHIFT;
    endfunction

endpackage

// File: rtl/x_src_skid.sv
// Two-entry valid/ready skid buffer between the RAM read port and the stream.
// The space output is asserted when one more read can be issued. That read
// lands on the edge after the word currently in flight, so the buffer can
// never overflow.
module x_src_skid
    import x_src_pkg::*;
#(
    parameter int W = 33
) (
    input  logic         s_axi_aclk,
    input  logic         s_axi_areset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         pending,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic         space
);

    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;
    logic [1:0]   count_q;
    logic         pop;
    logic [2:0]   fill;

    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;
    assign pop       = out_valid & out_ready;
    assign fill      = {1'b0, count_q} + {2'b0, pending} - {2'b0, pop};
    assign space     = (fill < 3'd2);

    // Head register drives the stream; the tail catches a word arriving while the head stalls.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else if (pop) begin
            if (count_q == 2'd2) begin
                head_q <= tail_q;
                if (in_valid) begin
                    tail_q <= in_data;
                end else begin
                    count_q <= 2'd1;
                end
            end else if (in_valid) begin
                head_q <= in_data;
            end else begin
                count_q <= 2'd0;
            end
        end else if (in_valid) begin
            if (count_q == 2'd0) begin
                head_q  <= in_data;
                count_q <= 2'd1;
            end else begin
                tail_q  <= in_data;
                count_q <= 2'd2;
            end
        end
    end

endmodule

// File: rtl/x_stream_source.sv
// AXI-Stream source that replays one stored input vector NUM_PASSES times
// into the perceptron layer. Optional build macro: X_SRC_PIXEL_NORM_EN
// (store 8-bit pixels and emit them as p << NORM_SHIFT in Q4.27).
module x_stream_source
    import x_src_pkg::*;
#(
    parameter int INPUT_SIZE = 784,
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int NUM_PASSES = 1
) (
    input  logic              s_axi_aclk,
    input  logic              s_axi_areset,
    input  logic              start,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_drop,
    output logic [DATA_W-1:0] x_tdata,
    output logic              x_tvalid,
    input  logic              x_tready,
    output logic              x_tlast,
    output logic              busy,
    output logic              done
);

`ifdef X_SRC_PIXEL_NORM_EN
    localparam int STORE_W = PIXEL_W;
`else
    localparam int STORE_W = DATA_W;
`endif

    localparam logic [ADDR_W:0]   SIZE_EXT  = (ADDR_W + 1)'(INPUT_SIZE);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(INPUT_SIZE - 1);
    localparam logic [7:0]        LAST_PASS = 8'(NUM_PASSES - 1);

    x_src_state_t      state_q;
    logic              start_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [7:0]        pass_q;
    logic [7:0]        out_pass_q;
    logic              reads_done_q;
    logic              rd_vld_q;
    logic              rd_last_q;
    logic [STORE_W-1:0] rd_data_q;
    logic [STORE_W-1:0] mem [INPUT_SIZE];

    logic              start_edge;
    logic              wr_ok;
    logic              at_last;
    logic              rd_en;
    logic              skid_space;
    logic              last_hs;
    logic              final_hs;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W:0]   skid_out;

    assign start_edge = start & ~start_q;
    assign wr_ok      = wr_en & (state_q == IDLE) & ({1'b0, wr_addr} < SIZE_EXT);
    assign at_last    = (rd_addr_q == LAST_ADDR);
    assign rd_en      = (state_q == PRIME) |
                        ((state_q == STREAM) & ~reads_done_q & skid_space);
    assign last_hs    = x_tvalid & x_tready & x_tlast;
    assign final_hs   = last_hs & (out_pass_q == LAST_PASS);

`ifdef X_SRC_PIXEL_NORM_EN
    assign rd_word = DATA_W'(pixel_to_q427(rd_data_q));
`else
    assign rd_word = rd_data_q;
`endif

    assign x_tdata = skid_out[DATA_W-1:0];
    assign x_tlast = skid_out[DATA_W];

    // Single-clock vector RAM: host writes only while idle, reads feed the skid buffer.
    always_ff @(posedge s_axi_aclk) begin
        if (wr_ok) begin
            mem[wr_addr] <= wr_data[STORE_W-1:0];
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr_q];
        end
    end

    // Control FSM: start detection, read address/pass sequencing and status pulses.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            state_q      <= IDLE;
            start_q      <= 1'b0;
            rd_addr_q    <= '0;
            pass_q       <= 8'd0;
            out_pass_q   <= 8'd0;
            reads_done_q <= 1'b0;
            rd_vld_q     <= 1'b0;
            rd_last_q    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            wr_drop      <= 1'b0;
        end else begin
            start_q   <= start;
            done      <= 1'b0;
            wr_drop   <= wr_en & ~wr_ok;
            rd_vld_q  <= rd_en;
            rd_last_q <= rd_en & at_last;
            if (rd_en) begin
                if (at_last) begin
                    rd_addr_q <= '0;
                    if (pass_q == LAST_PASS) begin
                        reads_done_q <= 1'b1;
                    end else begin
                        pass_q <= pass_q + 8'd1;
                    end
                end else begin
                    rd_addr_q <= rd_addr_q + ADDR_W'(1);
                end
            end
            if (last_hs) begin
                out_pass_q <= out_pass_q + 8'd1;
            end
            case (state_q)
                IDLE: begin
                    rd_addr_q    <= '0;
                    pass_q       <= 8'd0;
                    out_pass_q   <= 8'd0;
                    reads_done_q <= 1'b0;
                    if (start_edge & ~busy) begin
                        state_q <= PRIME;
                        busy    <= 1'b1;
                    end
                end
                PRIME: begin
                    state_q <= STREAM;
                end
                STREAM: begin
                    if (final_hs) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    x_src_skid #(
        .W (DATA_W + 1)
    ) u_skid (
        .s_axi_aclk   (s_axi_aclk),
        .s_axi_areset (s_axi_areset),
        .in_valid     (rd_vld_q),
        .in_data      ({rd_last_q, rd_word}),
        .pending      (rd_vld_q),
        .out_valid    (x_tvalid),
        .out_data     (skid_out),
        .out_ready    (x_tready),
        .space        (skid_space)
    );

endmodule

// File: tb/tb_x_stream_source.sv
// Self-checking bench for x_stream_source (NUM_PASSES=3, INPUT_SIZE=784).
// Works with or without X_SRC_PIXEL_NORM_EN; the reference model follows the macro.
module tb_x_stream_source;

    localparam int IS = 784;
    localparam int NP = 3;
    localparam int TOTAL = IS * NP;

    logic        s_axi_aclk;
    logic        s_axi_areset;
    logic        start;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_drop;
    logic [31:0] x_tdata;
    logic        x_tvalid;
    logic        x_tready;
    logic        x_tlast;
    logic        busy;
    logic        done;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] model_mem [IS];

    typedef struct {
        logic        wr_en;
        logic [9:0]  addr;
        logic [31:0] data;
        logic        exp_drop;
    } wr_vec_t;

    wr_vec_t vecs [6];

    x_stream_source #(
        .INPUT_SIZE (IS),
        .ADDR_W     (10),
        .DATA_W     (32),
        .NUM_PASSES (NP)
    ) dut (
        .s_axi_aclk   (s_axi_aclk),
        .s_axi_areset (s_axi_areset),
        .start        (start),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_drop      (wr_drop),
        .x_tdata      (x_tdata),
        .x_tvalid     (x_tvalid),
        .x_tready     (x_tready),
        .x_tlast      (x_tlast),
        .busy         (busy),
        .done         (done)
    );

    // Free-running 100 MHz clock.
    initial s_axi_aclk = 1'b0;
    always #5 s_axi_aclk = ~s_axi_aclk;

    // Global time bound so a stuck design still ends the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected stream word for a RAM address, from the stored value.
    function automatic logic [31:0] exp_word(input int a);
`ifdef X_SRC_PIXEL_NORM_EN
        return {24'd0, model_mem[a][7:0]} << 19;
`else
        return model_mem[a];
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
        end
    endtask

    // Drives one write at the current negedge and lets it be sampled for one cycle.
    task automatic applyStimulus(input wr_vec_t v);
        wr_en   = v.wr_en;
        wr_addr = v.addr;
        wr_data = v.data;
        if (v.wr_en && int'(v.addr) < IS) model_mem[v.addr] = v.data;
        @(negedge s_axi_aclk);
        wr_en = 1'b0;
    endtask

    task automatic load_ram(input bit random_data);
        for (int a = 0; a < IS; a++) begin
            @(negedge s_axi_aclk);
            wr_en   = 1'b1;
            wr_addr = 10'(a);
            wr_data = random_data ? $urandom : 32'(a + 1);
            model_mem[a] = wr_data;
        end
        @(negedge s_axi_aclk);
        wr_en = 1'b0;
    endtask

    // Raises start at the current negedge and follows one run. Loop index n is
    // the negedge after the n-th posedge counted from the one sampling the edge.
    task automatic run_stream(input string tag, input int ready_pct, input bit hold_start,
                              input int drop_n, input int reset_hs, input bit check_timing);
        int  exp_idx = 0;
        int  first_n = -1;
        int  last_n = -1;
        int  done_n = -1;
        int  done_cnt = 0;
        int  last_cnt = 0;
        bit  prev_stall = 0;
        bit  aborted = 0;
        int  limit;
        limit = hold_start ? 5010 : TOTAL * 4 + 200;
        start = 1'b1;
        for (int n = 0; n < limit; n++) begin
            @(negedge s_axi_aclk);
            start = hold_start ? ((n < 5000) && (n != 1000)) : 1'b0;
            wr_en = 1'b0;
            if (n == drop_n) begin
                wr_en   = 1'b1;
                wr_addr = 10'd5;
                wr_data = 32'hDEAD_BEEF;
            end
            if (drop_n >= 0 && n == drop_n + 1) checkOutput({tag, " wr_drop busy"}, 32'(wr_drop), 32'd1);
            if (drop_n >= 0 && n == drop_n + 2) checkOutput({tag, " wr_drop width"}, 32'(wr_drop), 32'd0);
            x_tready = ($urandom_range(0, 99) < ready_pct);
            if (n == 0) checkOutput({tag, " busy after start"}, 32'(busy), 32'd1);
            if (prev_stall) checkOutput({tag, " valid held"}, 32'(x_tvalid), 32'd1);
            if (x_tvalid) begin
                if (first_n < 0) first_n = n;
                if (exp_idx < TOTAL) begin
                    checkOutput({tag, " tdata"}, x_tdata, exp_word(exp_idx % IS));
                    checkOutput({tag, " tlast"}, 32'(x_tlast), 32'((exp_idx % IS) == IS - 1));
                end else begin
                    checkOutput({tag, " extra word"}, 32'(x_tvalid), 32'd0);
                end
            end
            if (x_tvalid && x_tready) begin
                if (x_tlast) last_cnt++;
                exp_idx++;
                if (exp_idx == TOTAL) last_n = n;
                if (reset_hs > 0 && exp_idx == reset_hs) begin
                    s_axi_areset = 1'b1;
                    @(negedge s_axi_aclk);
                    checkOutput({tag, " valid after reset"}, 32'(x_tvalid), 32'd0);
                    checkOutput({tag, " busy after reset"}, 32'(busy), 32'd0);
                    s_axi_areset = 1'b0;
                    repeat (5) begin
                        @(negedge s_axi_aclk);
                        checkOutput({tag, " no done after reset"}, 32'(done), 32'd0);
                    end
                    aborted = 1;
                    break;
                end
            end
            prev_stall = x_tvalid & ~x_tready;
            if (done) begin
                done_cnt++;
                if (done_n < 0) done_n = n;
                checkOutput({tag, " busy with done"}, 32'(busy), 32'd0);
            end
            if (done_n >= 0 && n >= done_n + 3 && (!hold_start || n >= 5005)) break;
        end
        start = 1'b0;
        wr_en = 1'b0;
        if (!aborted) begin
            checkOutput({tag, " handshakes"}, 32'(exp_idx), 32'(TOTAL));
            checkOutput({tag, " tlast count"}, 32'(last_cnt), 32'(NP));
            checkOutput({tag, " done count"}, 32'(done_cnt), 32'd1);
            checkOutput({tag, " first valid cycle"}, 32'(first_n), 32'd2);
            checkOutput({tag, " idle valid"}, 32'(x_tvalid), 32'd0);
            checkOutput({tag, " idle busy"}, 32'(busy), 32'd0);
            if (check_timing) begin
                checkOutput({tag, " last handshake cycle"}, 32'(last_n + 1), 32'(2 + TOTAL));
                checkOutput({tag, " done cycle"}, 32'(done_n), 32'(3 + TOTAL));
            end
        end
        repeat (2) @(negedge s_axi_aclk);
    endtask

    initial begin
        $display("[TB] x_stream_source bench starting");
        s_axi_areset = 1'b1;
        start        = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        x_tready     = 1'b0;
        repeat (3) @(negedge s_axi_aclk);
        checkOutput("reset x_tvalid", 32'(x_tvalid), 32'd0);
        checkOutput("reset x_tlast", 32'(x_tlast), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset wr_drop", 32'(wr_drop), 32'd0);
        checkOutput("reset x_tdata", x_tdata, 32'd0);
        s_axi_areset = 1'b0;

        load_ram(0);

        vecs[0] = '{1'b1, 10'd800,  32'h1111_0000, 1'b1};
        vecs[1] = '{1'b1, 10'd10,   32'h0000_0A0A, 1'b0};
        vecs[2] = '{1'b1, 10'd784,  32'h2222_0000, 1'b1};
        vecs[3] = '{1'b0, 10'd11,   32'h3333_0000, 1'b0};
        vecs[4] = '{1'b1, 10'd783,  32'h0000_0F0F, 1'b0};
        vecs[5] = '{1'b1, 10'd1023, 32'h4444_0000, 1'b1};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("idle wr_drop vec%0d", i), 32'(wr_drop), 32'(vecs[i].exp_drop));
        end
        repeat (2) @(negedge s_axi_aclk);

        // Write and start edge in the same idle cycle; stream must show the new word 0.
        wr_en   = 1'b1;
        wr_addr = 10'd0;
        wr_data = 32'hA5A5_0001;
        model_mem[0] = wr_data;
        run_stream("runA", 100, 0, 100, -1, 1);

        run_stream("runB", 50, 0, -1, -1, 0);

        load_ram(1);
        run_stream("runC", 100, 1, -1, -1, 0);

        run_stream("runD", 100, 0, -1, 300, 0);

`ifdef X_SRC_PIXEL_NORM_EN
        applyStimulus('{1'b1, 10'd0, 32'h0000_00FF, 1'b0});
        applyStimulus('{1'b1, 10'd1, 32'h0000_0001, 1'b0});
        @(negedge s_axi_aclk);
`endif
        run_stream("runE", 100, 0, -1, -1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
